// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap block.
// Contents:
//   - CSR address enumeration.
//   - CSR operation encoding.
//   - mstatus and mie bit indices.
//   - Trap cause codes.
//   - csr_alu: computes the value written by a CSR instruction.
package csr_trap_unit_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [30:0] CAUSE_ILLEGAL_INST = 31'd2;
  localparam logic [30:0] CAUSE_MTI          = 31'd7;
  localparam logic [30:0] CAUSE_MEI          = 31'd11;

  // Only MEIE and MTIE are implemented in mie.
  localparam logic [31:0] MIE_MASK = 32'h0000_0880;

  function automatic logic [31:0] csr_alu(input csr_op_t op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] wdata);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   inc            count one event this cycle
//   wr_lo, wr_hi   replace the low / high half with wdata
//   wdata          value for a half write
//   value          current count
// Behaviour on a half write:
//   - A low-half write holds the high half; no carry is propagated out of the low half.
//   - A high-half write lets the low half keep counting, but the low-half carry is dropped.
module csr_trap_unit_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] r_cnt;
  logic [31:0] w_lo_inc;

  assign w_lo_inc = r_cnt[31:0] + {31'd0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (wr_lo) begin
      r_cnt[31:0] <= wdata;
    end else if (wr_hi) begin
      r_cnt <= {wdata, w_lo_inc};
    end else begin
      r_cnt <= r_cnt + {63'd0, inc};
    end
  end

  assign value = r_cnt;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap state holder.
// Trap and mret handling:
//   - Trap entry captures mepc, mcause and mtval.
//   - Trap entry stacks mstatus.MIE into MPIE and clears MIE.
//   - mret restores MIE from MPIE and sets MPIE.
// Also serves CSR instructions from the memory stage and owns the mcycle/minstret counters.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   exception, exception_pc/cause/tval, interrupt   trap entry request
//   mret                           mret in memory stage
//   csr_valid, csr_op, csr_addr, csr_wdata, csr_wen  CSR access
//   inst_retire                    instruction retired this cycle
//   meip, mtip                     pending interrupt lines
//   csr_rdata, csr_illegal         CSR read value (old) and illegal-access flag
//   mtvec_base, mtvec_mode, mepc_out  trap vector / return target
//   irq_req, irq_cause             qualified interrupt request to exception unit
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_cause,
  input  logic [31:0] exception_tval,
  input  logic        interrupt,
  input  logic        mret,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wen,
  input  logic        inst_retire,
  input  logic        meip,
  input  logic        mtip,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec_base,
  output logic [1:0]  mtvec_mode,
  output logic [31:0] mepc_out,
  output logic        irq_req,
  output logic [31:0] irq_cause
);

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_mstatus;
  logic [31:0] w_mip;
  logic [31:0] w_pending;
  logic [31:0] w_rdata;
  logic [31:0] w_new;
  logic        w_known;
  logic        w_read_only;
  logic        w_we;
  csr_op_t     w_op;
  logic        w_unused_cause_msb;

  // The interrupt flag comes from `interrupt`, never from the cause word.
  assign w_unused_cause_msb = exception_cause[31];

  assign w_op = csr_op_t'(csr_op);

  // MPP is hardwired to machine mode (bits 12:11 = 2'b11).
  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mip     = {20'd0, meip, 3'd0, mtip, 7'd0};

  always_comb begin
    w_rdata = '0;
    w_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MISA:      w_rdata = MISA_VAL;
      CSR_MIE:       w_rdata = r_mie;
      CSR_MTVEC:     w_rdata = r_mtvec;
      CSR_MSCRATCH:  w_rdata = r_mscratch;
      CSR_MEPC:      w_rdata = r_mepc;
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MTVAL:     w_rdata = r_mtval;
      CSR_MIP:       w_rdata = w_mip;
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      CSR_MHARTID:   w_rdata = HART_ID;
      default:       w_known = 1'b0;
    endcase
  end

  assign csr_rdata   = w_rdata;
  assign w_read_only = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA) ||
                       (csr_addr == CSR_MIP);
  assign csr_illegal = csr_valid & (~w_known | (w_read_only & csr_wen));

  // A trap in the same cycle suppresses the CSR write entirely.
  assign w_we  = csr_valid & csr_wen & (w_op != CSR_OP_NONE) & ~csr_illegal & ~exception;
  assign w_new = csr_alu(w_op, w_rdata, csr_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (exception) begin
      r_mepc         <= exception_pc & ~32'd3;
      r_mcause       <= {interrupt, exception_cause[30:0]};
      r_mtval        <= exception_tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else begin
      // mret owns mstatus in its cycle; a concurrent mstatus write is dropped.
      if (mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we && (csr_addr == CSR_MSTATUS)) begin
        r_mstatus_mie  <= w_new[MSTATUS_MIE];
        r_mstatus_mpie <= w_new[MSTATUS_MPIE];
      end
      if (w_we) begin
        case (csr_addr)
          CSR_MIE:      r_mie      <= w_new & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= w_new & ~32'd2;
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= w_new & ~32'd3;
          CSR_MCAUSE:   r_mcause   <= w_new;
          CSR_MTVAL:    r_mtval    <= w_new;
          default:      ;
        endcase
      end
    end
  end

  csr_trap_unit_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (w_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi (w_we && (csr_addr == CSR_MCYCLEH)),
    .wdata (w_new),
    .value (w_mcycle)
  );

  csr_trap_unit_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_retire),
    .wr_lo (w_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi (w_we && (csr_addr == CSR_MINSTRETH)),
    .wdata (w_new),
    .value (w_minstret)
  );

  assign mtvec_base = {r_mtvec[31:2], 2'b00};
  assign mtvec_mode = {1'b0, r_mtvec[0]};
  assign mepc_out   = r_mepc;

  // External interrupt wins over timer interrupt when both are enabled and pending.
  assign w_pending = r_mie & w_mip;
  assign irq_req   = r_mstatus_mie & (|w_pending);
  assign irq_cause = w_pending[MIE_MEIE] ? {1'b1, CAUSE_MEI} : {1'b1, CAUSE_MTI};

endmodule
